// File: rtl/or1200_dfi_if.sv
// ----------------------------------------------------------------------------
// or1200_dfi_if
// Bundles the signals between the DFI return-address checker / SPR-PIC side
// and the DFI violation log.
//
//   viol_i       checker -> log   one-cycle violation event
//   viol_pc_i    checker -> log   PC of the offending load
//   viol_adr_i   checker -> log   effective address of the offending load
//   viol_kind_i  checker -> log   access size (0 word, 1 half, 2 byte, 3 rsvd)
//   irq_en_i     SPR     -> log   interrupt enable
//   rd_stb_i     SPR     -> log   read strobe
//   rd_sel_i     SPR     -> log   read field select
//   rd_dat_o     log     -> SPR   registered read data
//   rd_ack_o     log     -> SPR   read acknowledge
//   pop_i        SPR     -> log   discard head entry
//   clr_i        SPR     -> log   clear sticky overflow and drop counter
//   irq_o        log     -> PIC   level interrupt request
//
// master: the CPU-side driver (checker + SPR/PIC). slave: the log itself.
// ----------------------------------------------------------------------------
interface or1200_dfi_if;
  logic        viol_i;
  logic [31:0] viol_pc_i;
  logic [31:0] viol_adr_i;
  logic [1:0]  viol_kind_i;
  logic        irq_en_i;
  logic        rd_stb_i;
  logic [1:0]  rd_sel_i;
  logic [31:0] rd_dat_o;
  logic        rd_ack_o;
  logic        pop_i;
  logic        clr_i;
  logic        irq_o;

  modport master (
    output viol_i, viol_pc_i, viol_adr_i, viol_kind_i,
    output irq_en_i, rd_stb_i, rd_sel_i, pop_i, clr_i,
    input  rd_dat_o, rd_ack_o, irq_o
  );

  modport slave (
    input  viol_i, viol_pc_i, viol_adr_i, viol_kind_i,
    input  irq_en_i, rd_stb_i, rd_sel_i, pop_i, clr_i,
    output rd_dat_o, rd_ack_o, irq_o
  );
endinterface

// File: rtl/or1200_dfi_vlog.sv
// ----------------------------------------------------------------------------
// or1200_dfi_vlog
// Violation log for the DFI return-address checker. Each violation event
// (PC, address, access size) is queued in a 2^DEPTH_LOG2 entry FIFO that
// software drains through a registered SPR-style read port. Events arriving
// while the FIFO is full are dropped and accounted for in a sticky overflow
// flag plus a saturating 8-bit drop counter.
//
// Ports:
//   clk   clock, all state updates on posedge
//   rst   asynchronous active-high reset
//   bus   or1200_dfi_if.slave (violation input, read port, pop/clear, irq)
//
// Read fields (rd_sel_i):
//   0  head pc          (0 when empty)
//   1  head adr         (0 when empty)
//   2  status  {ovf, empty, full, 19'b0, head kind, 4'b0, count[3:0]}
//   3  {24'b0, drop_cnt}
// ----------------------------------------------------------------------------
module or1200_dfi_vlog #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input logic         clk,
  input logic         rst,
  or1200_dfi_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned AW    = DEPTH_LOG2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] adr;
    logic [1:0]  kind;
  } entry_t;

  // Storage and bookkeeping
  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW-1:0]   r_count;
  logic            r_ovf;
  logic [7:0]      r_drop_cnt;

  // Registered outputs
  logic [31:0]     r_rd_dat;
  logic            r_rd_ack;
  logic            r_irq;

  // Combinational helpers
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [PW-1:0]   w_count_n;
  logic            w_ovf_n;
  logic [7:0]      w_drop_cnt_n;
  entry_t          w_head;
  entry_t          w_new;
  logic [31:0]     w_rd_mux;

  // Pointers wrap modulo the depth, so the top bit stays clear.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy flags straight from registered count
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == PW'(DEPTH));

  // A pop on an empty FIFO is ignored; a pop on a full FIFO frees the slot
  // that a same-cycle event then takes, so nothing is dropped.
  assign w_pop  = bus.pop_i & ~w_empty;
  assign w_push = bus.viol_i & (~w_full | w_pop);
  assign w_drop = bus.viol_i & w_full & ~w_pop;

  assign w_head = r_mem[r_rptr[AW-1:0]];

  always_comb begin
    w_new      = '0;
    w_new.pc   = bus.viol_pc_i;
    w_new.adr  = bus.viol_adr_i;
    w_new.kind = bus.viol_kind_i;
  end

  // Next-state occupancy
  always_comb begin
    w_count_n = r_count;
    if (w_push && !w_pop) begin
      w_count_n = r_count + PW'(1);
    end else if (!w_push && w_pop) begin
      w_count_n = r_count - PW'(1);
    end
  end

  // Overflow accounting; a clear beats a coincident drop.
  always_comb begin
    w_ovf_n      = r_ovf;
    w_drop_cnt_n = r_drop_cnt;
    if (bus.clr_i) begin
      w_ovf_n      = 1'b0;
      w_drop_cnt_n = '0;
    end else if (w_drop) begin
      w_ovf_n = 1'b1;
      if (r_drop_cnt != 8'hFF) begin
        w_drop_cnt_n = r_drop_cnt + 8'd1;
      end
    end
  end

  // Read field select, sampled from pre-update state
  always_comb begin
    w_rd_mux = '0;
    case (bus.rd_sel_i)
      2'd0:    w_rd_mux = w_empty ? 32'h0 : w_head.pc;
      2'd1:    w_rd_mux = w_empty ? 32'h0 : w_head.adr;
      2'd2:    w_rd_mux = {r_ovf, w_empty, w_full, 19'b0,
                           (w_empty ? 2'b00 : w_head.kind), 4'b0000,
                           4'(r_count)};
      default: w_rd_mux = {24'b0, r_drop_cnt};
    endcase
  end

  // Entry storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_new;
    end
  end

  // FIFO bookkeeping and overflow state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      r_count    <= w_count_n;
      r_ovf      <= w_ovf_n;
      r_drop_cnt <= w_drop_cnt_n;
    end
  end

  // Read port: one-cycle ack, data holds between acks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ack <= 1'b0;
      r_rd_dat <= '0;
    end else begin
      r_rd_ack <= bus.rd_stb_i;
      if (bus.rd_stb_i) begin
        r_rd_dat <= w_rd_mux;
      end
    end
  end

  // Interrupt level computed from next-state occupancy and overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= bus.irq_en_i & ((w_count_n != '0) | w_ovf_n);
    end
  end

  assign bus.rd_dat_o = r_rd_dat;
  assign bus.rd_ack_o = r_rd_ack;
  assign bus.irq_o    = r_irq;

endmodule
